// File: rtl/arm_mc_ctrl.sv
// ============================================================================
//  Module   : arm_mc_ctrl
//  Brief    : Multicycle ARM control unit. A Moore FSM sequences the datapath
//             through fetch/decode/execute, the ALU decoder maps cmd to an ALU
//             operation, and conditional logic gates every architectural write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Raw per-state controls, before condition gating
    typedef struct packed {
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       irw;
        logic       fetch;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
    } ctl_t;

    function automatic ctl_t decode_state(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.irw       = 1'b1;
                c.fetch     = 1'b1;
            end
            S_DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_MEMADR:   c.alusrcb = 2'b01;
            S_MEMREAD:  c.adrsrc  = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            S_EXECUTER: c.aluop = 1'b1;
            S_EXECUTEI: begin
                c.alusrcb = 2'b01;
                c.aluop   = 1'b1;
            end
            S_ALUWB:    c.regw = 1'b1;
            S_BRANCH: begin
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.branch    = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t     r_state;
    state_t     w_next;
    ctl_t       r_ctl;
    logic [3:0] r_flags;
    logic       r_condexr;
    logic       w_condex;
    logic [1:0] w_aludec;
    logic       w_nowr_dec;
    logic       w_addsub;
    logic       w_cmp;
    logic       w_nowrite;
    logic [1:0] w_flagw;
    logic       w_rd15;

    // Next-state selection from the current state and instruction fields
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // ALU decoder: cmd to operation, plus compare/unsupported write suppression
    always_comb begin
        w_aludec   = 2'b00;
        w_nowr_dec = 1'b0;
        w_addsub   = 1'b0;
        w_cmp      = 1'b0;
        case (Funct[4:1])
            4'b0100: w_addsub = 1'b1;
            4'b0010: begin
                w_aludec = 2'b01;
                w_addsub = 1'b1;
            end
            4'b0000: w_aludec = 2'b10;
            4'b1100: w_aludec = 2'b11;
            4'b1010: begin
                w_aludec   = 2'b01;
                w_nowr_dec = 1'b1;
                w_cmp      = 1'b1;
            end
            default: w_nowr_dec = 1'b1;
        endcase
    end

    // Condition evaluation against the stored NZCV flags
    always_comb begin
        w_condex = 1'b0;
        case (Cond)
            4'b0000: w_condex = r_flags[2];
            4'b0001: w_condex = ~r_flags[2];
            4'b0010: w_condex = r_flags[1];
            4'b0011: w_condex = ~r_flags[1];
            4'b0100: w_condex = r_flags[3];
            4'b0101: w_condex = ~r_flags[3];
            4'b0110: w_condex = r_flags[0];
            4'b0111: w_condex = ~r_flags[0];
            4'b1000: w_condex = r_flags[1] & ~r_flags[2];
            4'b1001: w_condex = ~r_flags[1] | r_flags[2];
            4'b1010: w_condex = (r_flags[3] == r_flags[0]);
            4'b1011: w_condex = (r_flags[3] != r_flags[0]);
            4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // The write-suppress decode only concerns data-processing instructions
    assign w_nowrite  = (Op == 2'b00) & w_nowr_dec;
    assign w_flagw[1] = r_ctl.aluop & (Funct[0] | w_cmp);
    assign w_flagw[0] = r_ctl.aluop & ((Funct[0] & w_addsub) | w_cmp);
    assign w_rd15     = (Rd == 4'hF);

    // State, registered per-state controls, latched condition and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctl     <= decode_state(S_FETCH);
            r_flags   <= 4'b0000;
            r_condexr <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctl   <= decode_state(w_next);
            if (r_state == S_DECODE) begin
                r_condexr <= w_condex;
            end
            if (w_flagw[1] & r_condexr) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flagw[0] & r_condexr) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Write enables are forced low for as long as reset is held
    assign IRWrite  = rst_n & r_ctl.irw;
    assign MemWrite = rst_n & r_ctl.memw & r_condexr;
    assign RegWrite = rst_n & r_ctl.regw & r_condexr & ~w_nowrite
                      & ~(w_rd15 & (Op == 2'b00));
    assign PCWrite  = rst_n & (r_ctl.fetch | (r_ctl.branch & r_condexr)
                      | (r_ctl.regw & w_rd15 & r_condexr));

    assign AdrSrc     = r_ctl.adrsrc;
    assign ALUSrcA    = r_ctl.alusrca;
    assign ALUSrcB    = r_ctl.alusrcb;
    assign ResultSrc  = r_ctl.resultsrc;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    assign ALUControl = r_ctl.aluop ? w_aludec : 2'b00;
    assign Flags      = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_arm_mc_ctrl.sv
// ============================================================================
//  Module   : tb_arm_mc_ctrl
//  Brief    : Scoreboard bench for arm_mc_ctrl. Directed instructions push the
//             expected per-cycle control vector; a negedge monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags;

    arm_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
    );

    always #5 clk = ~clk;

    localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4;
    localparam int MW = 5, ER = 6, EI = 7, AW = 8, BR = 9, RS = 10;

    typedef struct {
        string       name;
        logic [15:0] v;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_tag  = "init";

    wire [15:0] obs = {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                       ALUSrcB, ResultSrc, ALUControl, Flags};

    function automatic string sname(input int s);
        case (s)
            FE: return "FETCH";    DE: return "DECODE";   MA: return "MEMADR";
            MR: return "MEMREAD";  MB: return "MEMWB";    MW: return "MEMWRITE";
            ER: return "EXECUTER"; EI: return "EXECUTEI"; AW: return "ALUWB";
            BR: return "BRANCH";   default: return "RESET";
        endcase
    endfunction

    // Expected vector: state selects from the hand table, writes/flags given
    task automatic push(input int st, input bit pcw, input bit regw, input bit memw,
                        input logic [1:0] aluc, input logic [3:0] fl);
        logic       adr, a, irw;
        logic [1:0] b, r;
        exp_t       e;
        {adr, a, b, r} = 6'b0;
        irw = (st == FE);
        case (st)
            FE, DE, RS: begin a = 1'b1; b = 2'b10; r = 2'b10; end
            MA, EI:     b = 2'b01;
            MR, MW:     adr = 1'b1;
            MB:         r = 2'b01;
            BR:         begin b = 2'b01; r = 2'b10; end
            default:    ;
        endcase
        e.name = {cur_tag, ".", sname(st)};
        e.v    = {irw, pcw, regw, memw, adr, a, b, r, aluc, fl};
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [3:0] got, input logic [3:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %b expected %b", n, got, expv);
    endtask

    task automatic start(input string tag, input logic [3:0] c, input logic [1:0] o,
                         input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
        cur_tag  = tag;
        Cond     = c;
        Op       = o;
        Funct    = f;
        Rd       = rd;
        ALUFlags = af;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with an outstanding expectation is compared
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_checks++;
            if (obs === e.v) n_pass++;
            else $display("FAIL %s: got {irw,pcw,regw,memw,adr,a,b,res,aluc,nzcv}=%b expected %b",
                          e.name, obs, e.v);
        end
    end

    initial begin
        rst_n = 1'b0;
        start("reset", 4'hE, 2'b00, 6'b0, 4'h0, 4'h0);
        push(RS, 0, 0, 0, 2'b00, 4'h0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADDI (I bit set), no S: flags must ignore ALUFlags
        start("addi", 4'hE, 2'b00, 6'b101000, 4'h1, 4'hF);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(EI, 0, 0, 0, 2'b00, 4'h0); push(AW, 0, 1, 0, 2'b00, 4'h0);
        run(4);

        // CMP: SUB on the ALU, flags load, never a register write
        start("cmp", 4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(ER, 0, 0, 0, 2'b01, 4'h0); push(AW, 0, 0, 0, 2'b00, 4'b0100);
        run(4);

        // STREQ with Z=1: store happens
        start("str_eq", 4'h0, 2'b01, 6'b011000, 4'h2, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'b0100); push(DE, 0, 0, 0, 2'b00, 4'b0100);
        push(MA, 0, 0, 0, 2'b00, 4'b0100); push(MW, 0, 0, 1, 2'b00, 4'b0100);
        run(4);

        // Reset asserted during MEMWRITE aborts the store and clears flags
        start("str_rst", 4'hE, 2'b01, 6'b011000, 4'h2, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'b0100); push(DE, 0, 0, 0, 2'b00, 4'b0100);
        push(MA, 0, 0, 0, 2'b00, 4'b0100); push(MW, 0, 0, 1, 2'b00, 4'b0100);
        run(3);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.MemWrite", {3'b0, MemWrite}, 4'h0);
        chk("rst_mid.Flags", Flags, 4'h0);
        cur_tag = "rst_mid";
        push(RS, 0, 0, 0, 2'b00, 4'h0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LDREQ with Z=0: five cycles, no register write
        start("ldr_eq", 4'h0, 2'b01, 6'b011001, 4'h3, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(MA, 0, 0, 0, 2'b00, 4'h0); push(MR, 0, 0, 0, 2'b00, 4'h0);
        push(MB, 0, 0, 0, 2'b00, 4'h0);
        run(5);

        // LDRNE with Z=0: register write in MEMWB
        start("ldr_ne", 4'h1, 2'b01, 6'b011001, 4'h3, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(MA, 0, 0, 0, 2'b00, 4'h0); push(MR, 0, 0, 0, 2'b00, 4'h0);
        push(MB, 0, 1, 0, 2'b00, 4'h0);
        run(5);

        // Branch always, then branch never
        start("b_al", 4'hE, 2'b10, 6'b100000, 4'h0, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(BR, 1, 0, 0, 2'b00, 4'h0);
        run(3);
        start("b_nv", 4'hF, 2'b10, 6'b100000, 4'h0, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(BR, 0, 0, 0, 2'b00, 4'h0);
        run(3);

        // Illegal class: two cycles, no writes
        start("illegal", 4'hE, 2'b11, 6'b111111, 4'hF, 4'hF);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        run(2);

        // SUBS loads all four flags
        start("subs", 4'hE, 2'b00, 6'b000101, 4'h4, 4'b1011);
        push(FE, 1, 0, 0, 2'b00, 4'h0); push(DE, 0, 0, 0, 2'b00, 4'h0);
        push(ER, 0, 0, 0, 2'b01, 4'h0); push(AW, 0, 1, 0, 2'b00, 4'b1011);
        run(4);

        // ANDS loads only N and Z
        start("ands", 4'hE, 2'b00, 6'b000001, 4'h5, 4'b0100);
        push(FE, 1, 0, 0, 2'b00, 4'b1011); push(DE, 0, 0, 0, 2'b00, 4'b1011);
        push(ER, 0, 0, 0, 2'b10, 4'b1011); push(AW, 0, 1, 0, 2'b00, 4'b0111);
        run(4);

        // ORRSNE immediate with Z=1: fails, no write, flags unchanged
        start("orrs_ne", 4'h1, 2'b00, 6'b111001, 4'h6, 4'b1000);
        push(FE, 1, 0, 0, 2'b00, 4'b0111); push(DE, 0, 0, 0, 2'b00, 4'b0111);
        push(EI, 0, 0, 0, 2'b11, 4'b0111); push(AW, 0, 0, 0, 2'b00, 4'b0111);
        run(4);

        // ADDCS to R15 (C=1): PC written, register file not
        start("add_pc", 4'h2, 2'b00, 6'b001000, 4'hF, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'b0111); push(DE, 0, 0, 0, 2'b00, 4'b0111);
        push(ER, 0, 0, 0, 2'b00, 4'b0111); push(AW, 1, 0, 0, 2'b00, 4'b0111);
        run(4);

        // LDRHI to R15 (C=1,Z=1 fails), then LDRLS to R15 (passes)
        start("ldr_pc_hi", 4'h8, 2'b01, 6'b011001, 4'hF, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'b0111); push(DE, 0, 0, 0, 2'b00, 4'b0111);
        push(MA, 0, 0, 0, 2'b00, 4'b0111); push(MR, 0, 0, 0, 2'b00, 4'b0111);
        push(MB, 0, 0, 0, 2'b00, 4'b0111);
        run(5);
        start("ldr_pc_ls", 4'h9, 2'b01, 6'b011001, 4'hF, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'b0111); push(DE, 0, 0, 0, 2'b00, 4'b0111);
        push(MA, 0, 0, 0, 2'b00, 4'b0111); push(MR, 0, 0, 0, 2'b00, 4'b0111);
        push(MB, 1, 1, 0, 2'b00, 4'b0111);
        run(5);

        // Back in FETCH after the last instruction
        start("end", 4'hE, 2'b00, 6'b101000, 4'h0, 4'h0);
        push(FE, 1, 0, 0, 2'b00, 4'b0111);
        run(1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
